// File: rtl/amiq_muxn_1_if.sv
// amiq_muxn_1 bus: channel inputs, select/scan controls
// and registered mux outputs.
interface amiq_muxn_1_if #(
  parameter int NOF_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 8
);
  localparam int SEL_W = (NOF_CH > 1) ? $clog2(NOF_CH) : 1;

  logic [NOF_CH*WIDTH-1:0] in_data;
  logic [NOF_CH-1:0]       in_valid;
  logic [SEL_W-1:0]        sel;
  logic                    mode;
  logic [DWELL_W-1:0]      dwell;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic [SEL_W-1:0]        out_ch;
  logic                    sel_err;

  modport master (
    output in_data, in_valid, sel, mode, dwell,
    input  out, out_valid, out_ch, sel_err
  );

  modport slave (
    input  in_data, in_valid, sel, mode, dwell,
    output out, out_valid, out_ch, sel_err
  );
endinterface

// File: rtl/amiq_muxn_1.sv
// N-channel registered mux with per-channel valid,
// round-robin auto-scan and illegal-select flag.
module amiq_muxn_1 #(
  parameter int NOF_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  amiq_muxn_1_if.slave  bus
);
  localparam int SEL_W = (NOF_CH > 1) ? $clog2(NOF_CH) : 1;
  localparam logic [SEL_W:0] NCH =
    (SEL_W+1)'(NOF_CH);
  localparam logic [SEL_W-1:0] LAST =
    SEL_W'(NOF_CH-1);

  logic [SEL_W-1:0]   ch_q;
  logic [SEL_W-1:0]   ch_d;
  logic [SEL_W-1:0]   ch_eff;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic               sel_bad;
  logic [WIDTH-1:0]   dat;
  logic               vld;
  logic [WIDTH-1:0]   out_q;
  logic               vld_q;
  logic [SEL_W-1:0]   och_q;
  logic               err_q;

  always_comb begin
    sel_bad = !bus.mode && ({1'b0, bus.sel} >= NCH);
    ch_eff  = bus.sel;
    unique case (1'b1)
      bus.mode: ch_eff = ch_q;
      sel_bad:  ch_eff = ch_q;
      default:  ch_eff = bus.sel;
    endcase
  end

  always_comb begin
    dat = '0;
    vld = 1'b0;
    for (int k = 0; k < NOF_CH; k++) begin
      if (ch_eff == SEL_W'(k)) begin
        dat = bus.in_data[k*WIDTH +: WIDTH];
        vld = bus.in_valid[k];
      end
    end
  end

  // cnt_q only grows while below dwell, so it cannot wrap
  always_comb begin
    ch_d  = ch_eff;
    cnt_d = '0;
    if (bus.mode) begin
      if (cnt_q >= bus.dwell) begin
        ch_d  = (ch_q == LAST) ? '0 : ch_q + 1'b1;
        cnt_d = '0;
      end else begin
        ch_d  = ch_q;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q  <= '0;
      cnt_q <= '0;
    end else begin
      ch_q  <= ch_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
      och_q <= '0;
      err_q <= 1'b0;
    end else begin
      out_q <= dat;
      vld_q <= vld;
      och_q <= ch_eff;
      err_q <= sel_bad;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;
  assign bus.out_ch    = och_q;
  assign bus.sel_err   = err_q;
endmodule
